// File: rtl/axis_wr_arbiter_pkg.sv
// rtl/axis_wr_arbiter_pkg.sv - shared AXI write-path definitions for the axis blocks
//
// Contents:
//   bresp_e       AXI write response codes
//   AXI_* consts  static AW sideband values shared by every axis write block
//   burst_size()  AXI AxSIZE encoding for a given data-bus width in bits

package axis_wr_arbiter_pkg;

    typedef enum logic [1:0] {
        BRESP_OKAY   = 2'b00,
        BRESP_EXOKAY = 2'b01,
        BRESP_SLVERR = 2'b10,
        BRESP_DECERR = 2'b11
    } bresp_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [3:0] AXI_CACHE      = 4'b0011;
    localparam logic [2:0] AXI_PROT       = 3'b000;
    localparam logic [3:0] AXI_QOS        = 4'b0000;
    localparam logic       AXI_LOCK       = 1'b0;

    // Bytes per beat as log2, saturating at 128 bytes (1024-bit bus).
    function automatic logic [2:0] burst_size(input int data_width);
        case (data_width)
            8:       burst_size = 3'd0;
            16:      burst_size = 3'd1;
            32:      burst_size = 3'd2;
            64:      burst_size = 3'd3;
            128:     burst_size = 3'd4;
            256:     burst_size = 3'd5;
            512:     burst_size = 3'd6;
            default: burst_size = 3'd7;
        endcase
    endfunction

endpackage

// File: rtl/axis_order_fifo.sv
// rtl/axis_order_fifo.sv - register FIFO recording the channel order of granted AW bursts
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   push, push_data   write an entry (ignored when full unless popping the same cycle)
//   pop               drop the head entry (ignored when empty)
//   pop_data          current head entry
//   full, empty       occupancy flags

module axis_order_fifo #(
    parameter int WIDTH  = 2,
    parameter int AWIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << AWIDTH;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [AWIDTH-1:0] wr_ptr;
    logic [AWIDTH-1:0] rd_ptr;
    logic [AWIDTH:0]   count;
    logic              do_push;
    logic              do_pop;

    assign full     = (count == (AWIDTH+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AWIDTH'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AWIDTH'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (AWIDTH+1)'(1);
            end else if (do_pop && !do_push) begin
                count <= count - (AWIDTH+1)'(1);
            end
        end
    end

endmodule

// File: rtl/axis_wr_arbiter.sv
// rtl/axis_wr_arbiter.sv - round-robin merge of NUM_CH burst masters onto one AXI write port
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   ch_aw*  (addr/len/valid/ready)   per-channel burst requests, channel i in slice i
//   ch_w*   (data/last/valid/ready)  per-channel write beats
//   ch_bvalid, ch_bresp              one-cycle registered response pulse per channel
//   ch_busy                          channel has bursts outstanding
//   ch_error, ch_err_clear           sticky non-OKAY response flag and its clear
//   axi_aw*, axi_w*, axi_b*          merged AXI write port; AWID/WID carry the channel index

module axis_wr_arbiter
    import axis_wr_arbiter_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int CH_WIDTH       = 2,
    parameter int ORDER_AWIDTH   = 4,
    parameter int OUT_WIDTH      = 8,
    parameter int AXI_ID_WIDTH   = 8,
    parameter int AXI_LEN_WIDTH  = 8,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 256
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_CH*AXI_ADDR_WIDTH-1:0]   ch_awaddr,
    input  logic [NUM_CH*AXI_LEN_WIDTH-1:0]    ch_awlen,
    input  logic [NUM_CH-1:0]                  ch_awvalid,
    output logic [NUM_CH-1:0]                  ch_awready,
    input  logic [NUM_CH*AXI_DATA_WIDTH-1:0]   ch_wdata,
    input  logic [NUM_CH-1:0]                  ch_wlast,
    input  logic [NUM_CH-1:0]                  ch_wvalid,
    output logic [NUM_CH-1:0]                  ch_wready,
    output logic [NUM_CH-1:0]                  ch_bvalid,
    output logic [NUM_CH*2-1:0]                ch_bresp,
    output logic [NUM_CH-1:0]                  ch_busy,
    output logic [NUM_CH-1:0]                  ch_error,
    input  logic [NUM_CH-1:0]                  ch_err_clear,
    input  logic                               axi_awready,
    output logic [AXI_ID_WIDTH-1:0]            axi_awid,
    output logic [AXI_ADDR_WIDTH-1:0]          axi_awaddr,
    output logic [AXI_LEN_WIDTH-1:0]           axi_awlen,
    output logic                               axi_awvalid,
    input  logic                               axi_wready,
    output logic [AXI_ID_WIDTH-1:0]            axi_wid,
    output logic [AXI_DATA_WIDTH-1:0]          axi_wdata,
    output logic                               axi_wlast,
    output logic                               axi_wvalid,
    input  logic [AXI_ID_WIDTH-1:0]            axi_bid,
    input  logic [1:0]                         axi_bresp,
    input  logic                               axi_bvalid,
    output logic                               axi_bready
);

    logic [OUT_WIDTH-1:0] out_cnt [NUM_CH];
    logic [NUM_CH-1:0]    eligible;
    logic [NUM_CH-1:0]    cnt_inc;
    logic [NUM_CH-1:0]    cnt_dec;
    logic [NUM_CH-1:0]    b_hit;
    logic [NUM_CH-1:0]    err_set;
    logic [CH_WIDTH-1:0]  last_grant;
    logic [CH_WIDTH-1:0]  grant;
    logic [CH_WIDTH-1:0]  cand;
    logic                 found;
    logic                 slot_free;
    logic                 grant_valid;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic [CH_WIDTH-1:0]  head;
    logic [CH_WIDTH-1:0]  b_ch;
    logic                 unused_bid_hi;

    assign b_ch          = axi_bid[CH_WIDTH-1:0];
    assign unused_bid_hi = ^axi_bid[AXI_ID_WIDTH-1:CH_WIDTH];
    assign axi_bready    = 1'b1;

    // The AW register may reload in the same cycle the slave takes its content.
    assign slot_free   = !axi_awvalid || axi_awready;
    assign grant_valid = slot_free && found;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            eligible[i] = ch_awvalid[i] && (out_cnt[i] != '1) && !fifo_full;
        end
    end

    // Cyclic search starting just after the previous winner.
    always_comb begin
        grant = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = CH_WIDTH'((int'(last_grant) + k) % NUM_CH);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ch_awready[i] = grant_valid && (grant == CH_WIDTH'(i));
            ch_wready[i]  = !fifo_empty && axi_wready && (head == CH_WIDTH'(i));
            b_hit[i]      = axi_bvalid && (b_ch == CH_WIDTH'(i));
            err_set[i]    = b_hit[i] && (axi_bresp != BRESP_OKAY);
            cnt_inc[i]    = ch_awready[i];
            // A response for a channel with nothing outstanding is not counted.
            cnt_dec[i]    = b_hit[i] && (out_cnt[i] != '0);
            ch_busy[i]    = (out_cnt[i] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            axi_awvalid <= 1'b0;
            axi_awid    <= '0;
            axi_awaddr  <= '0;
            axi_awlen   <= '0;
            last_grant  <= CH_WIDTH'(NUM_CH - 1);
        end else if (grant_valid) begin
            axi_awvalid <= 1'b1;
            axi_awid    <= AXI_ID_WIDTH'(grant);
            axi_awaddr  <= ch_awaddr[int'(grant)*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
            axi_awlen   <= ch_awlen[int'(grant)*AXI_LEN_WIDTH +: AXI_LEN_WIDTH];
            last_grant  <= grant;
        end else if (axi_awready) begin
            axi_awvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                out_cnt[i] <= '0;
            end
            ch_bvalid <= '0;
            ch_bresp  <= '0;
            ch_error  <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (cnt_inc[i] && !cnt_dec[i]) begin
                    out_cnt[i] <= out_cnt[i] + OUT_WIDTH'(1);
                end else if (cnt_dec[i] && !cnt_inc[i]) begin
                    out_cnt[i] <= out_cnt[i] - OUT_WIDTH'(1);
                end
                ch_bresp[2*i +: 2] <= b_hit[i] ? axi_bresp : 2'b00;
            end
            ch_bvalid <= b_hit;
            // A new error in the clearing cycle must not be lost.
            ch_error  <= (ch_error & ~ch_err_clear) | err_set;
        end
    end

    axis_order_fifo #(
        .WIDTH  (CH_WIDTH),
        .AWIDTH (ORDER_AWIDTH)
    ) u_order_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (grant_valid),
        .push_data (grant),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // W beats follow the channel at the head of the order FIFO.
    assign axi_wvalid = !fifo_empty && ch_wvalid[head];
    assign axi_wlast  = !fifo_empty && ch_wlast[head];
    assign axi_wid    = fifo_empty ? '0 : AXI_ID_WIDTH'(head);
    assign axi_wdata  = fifo_empty ? '0 : ch_wdata[int'(head)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
    assign fifo_pop   = axi_wvalid && axi_wready && axi_wlast;

endmodule
